// File: rtl/zbuff_resolve.sv
// ---------------------------------------------------------------------------
// zbuff_resolve
//
// Multisample resolve engine. Scans the subsample color store in raster
// order, averages the n*n subsamples of each pixel (n = 1/2/4/8 per axis)
// and streams one resolved color per pixel over a valid/ready handshake.
//
// Optional feature macro: ZBUFF_RESOLVE_ROUND_EN
//   defined   : averaging rounds half-up, (acc + 2^(shift-1)) >> shift
//   undefined : averaging truncates, acc >> shift
//   Cycle timing is the same either way.
//
// Ports
//   clk                 clock, all logic on the rising edge
//   rst                 synchronous reset, active low
//   start_RnnnnH        begin a resolve pass (only looked at while idle)
//   screen_RnnnnS[1:0]  {height, width}, signed fixed point, integer part used
//   subSample_RnnnnU    one-hot per-axis rate: 1000=1 0100=2 0010=4 0001=8
//   rd_en_RnnnnH        sample store read strobe
//   rd_addr_RnnnnU      sample address {y, x, ss_y, ss_x}
//   rd_data_RnnnnU      sample color, channel 0 in the LSBs, one cycle latency
//   pix_valid_RnnnnH    resolved pixel available
//   pix_ready_RnnnnH    consumer accepts the pixel
//   pix_x_RnnnnU        pixel column
//   pix_y_RnnnnU        pixel row
//   pix_color_RnnnnU    resolved color, one entry per channel
//   pix_last_RnnnnH     final pixel of the frame
//   busy_RnnnnH         engine is not idle
//   done_RnnnnH         one-cycle pulse at the end of a pass
// ---------------------------------------------------------------------------
module zbuff_resolve #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int FB_L2  = 11,
    parameter int SS_L2  = 3,
    parameter int COLORS = 3,
    parameter int COLORP = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_RnnnnH,
    input  logic signed [SIGFIG-1:0]        screen_RnnnnS [1:0],
    input  logic [3:0]                      subSample_RnnnnU,
    output logic                            rd_en_RnnnnH,
    output logic [2*FB_L2+2*SS_L2-1:0]      rd_addr_RnnnnU,
    input  logic [COLORS*COLORP-1:0]        rd_data_RnnnnU,
    output logic                            pix_valid_RnnnnH,
    input  logic                            pix_ready_RnnnnH,
    output logic [FB_L2-1:0]                pix_x_RnnnnU,
    output logic [FB_L2-1:0]                pix_y_RnnnnU,
    output logic [COLORP-1:0]               pix_color_RnnnnU [COLORS-1:0],
    output logic                            pix_last_RnnnnH,
    output logic                            busy_RnnnnH,
    output logic                            done_RnnnnH
);

    localparam int IW = SIGFIG - RADIX;   // integer part of a screen dimension
    localparam int AW = COLORP + 6;       // holds 64 full-scale samples
    localparam int RW = AW + 1;           // headroom for the rounding bias

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ACC,
        S_OUT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    // Frame configuration, captured once per pass.
    logic [IW-1:0]    x_max;
    logic [IW-1:0]    y_max;
    logic [1:0]       rate_l2;      // log2 of samples per axis
    logic [1:0]       rate_l2_in;

    // Scan position.
    logic [FB_L2-1:0] x;
    logic [FB_L2-1:0] y;
    logic [SS_L2-1:0] ss_x;
    logic [SS_L2-1:0] ss_y;

    logic             rd_en_d;      // read data lands on the bus this cycle
    logic [AW-1:0]    acc    [COLORS-1:0];
    logic [RW-1:0]    sum    [COLORS-1:0];
    logic [COLORP-1:0] scaled [COLORS-1:0];

    logic [IW-1:0]    width_in;
    logic [IW-1:0]    height_in;
    logic [SS_L2-1:0] ss_last;
    logic [2:0]       shift;
    logic             last_sample;
    logic             x_wrap;
    logic             y_wrap;
    logic             last_pixel;

    assign width_in  = screen_RnnnnS[0][SIGFIG-1:RADIX];
    assign height_in = screen_RnnnnS[1][SIGFIG-1:RADIX];

    // Fractional bits of the screen size play no part in the scan.
    logic unused_fraction;
    assign unused_fraction = ^{screen_RnnnnS[0][RADIX-1:0], screen_RnnnnS[1][RADIX-1:0]};

    // Anything that is not exactly one-hot falls back to one sample per pixel.
    always_comb begin
        case (subSample_RnnnnU)
            4'b0100: rate_l2_in = 2'd1;
            4'b0010: rate_l2_in = 2'd2;
            4'b0001: rate_l2_in = 2'd3;
            default: rate_l2_in = 2'd0;
        endcase
    end

    assign ss_last     = SS_L2'((4'd1 << rate_l2) - 4'd1);
    assign shift       = {rate_l2, 1'b0};          // divide by n*n
    assign last_sample = (ss_x == ss_last) && (ss_y == ss_last);
    assign x_wrap      = (IW'(x) == x_max - IW'(1));
    assign y_wrap      = (IW'(y) == y_max - IW'(1));
    assign last_pixel  = x_wrap && y_wrap;

    assign rd_addr_RnnnnU = {y, x, ss_y, ss_x};
    assign pix_x_RnnnnU   = x;
    assign pix_y_RnnnnU   = y;

    // Running sum including the sample currently on the read bus, and the
    // averaged value loaded into the output register in ACC.
    always_comb begin
        for (int c = 0; c < COLORS; c++) begin
            sum[c] = RW'(acc[c]) + RW'(rd_data_RnnnnU[c*COLORP +: COLORP]);
`ifdef ZBUFF_RESOLVE_ROUND_EN
            if (shift != 3'd0)
                scaled[c] = COLORP'((sum[c] + (RW'(1) << (shift - 3'd1))) >> shift);
            else
                scaled[c] = COLORP'(sum[c]);
`else
            scaled[c] = COLORP'(sum[c] >> shift);
`endif
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx         = state;
        rd_en_RnnnnH     = 1'b0;
        pix_valid_RnnnnH = 1'b0;
        pix_last_RnnnnH  = 1'b0;
        done_RnnnnH      = 1'b0;
        busy_RnnnnH      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_RnnnnH)
                    state_nx = (width_in == '0 || height_in == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                rd_en_RnnnnH = 1'b1;
                if (last_sample) state_nx = S_ACC;
            end
            S_ACC: begin
                state_nx = S_OUT;
            end
            S_OUT: begin
                pix_valid_RnnnnH = 1'b1;
                pix_last_RnnnnH  = last_pixel;
                if (pix_ready_RnnnnH) state_nx = last_pixel ? S_DONE : S_READ;
            end
            S_DONE: begin
                done_RnnnnH = 1'b1;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_max   <= '0;
            y_max   <= '0;
            rate_l2 <= '0;
            x       <= '0;
            y       <= '0;
            ss_x    <= '0;
            ss_y    <= '0;
            rd_en_d <= 1'b0;
            for (int c = 0; c < COLORS; c++) begin
                acc[c]              <= '0;
                pix_color_RnnnnU[c] <= '0;
            end
        end else begin
            rd_en_d <= rd_en_RnnnnH;
            case (state)
                S_IDLE: begin
                    if (start_RnnnnH) begin
                        x_max   <= width_in;
                        y_max   <= height_in;
                        rate_l2 <= rate_l2_in;
                        x       <= '0;
                        y       <= '0;
                        ss_x    <= '0;
                        ss_y    <= '0;
                        for (int c = 0; c < COLORS; c++) acc[c] <= '0;
                    end
                end
                S_READ: begin
                    // ss_x runs fastest; both wrap to 0 after the last sample.
                    if (ss_x == ss_last) begin
                        ss_x <= '0;
                        ss_y <= (ss_y == ss_last) ? '0 : ss_y + SS_L2'(1);
                    end else begin
                        ss_x <= ss_x + SS_L2'(1);
                    end
                    // The first READ cycle of a pixel has no data returning yet.
                    if (rd_en_d)
                        for (int c = 0; c < COLORS; c++) acc[c] <= AW'(sum[c]);
                end
                S_ACC: begin
                    // The final sample is absorbed here straight off the bus.
                    for (int c = 0; c < COLORS; c++) pix_color_RnnnnU[c] <= scaled[c];
                end
                S_OUT: begin
                    if (pix_ready_RnnnnH) begin
                        for (int c = 0; c < COLORS; c++) acc[c] <= '0;
                        if (last_pixel) begin
                            x <= '0;
                            y <= '0;
                        end else if (x_wrap) begin
                            x <= '0;
                            y <= y + FB_L2'(1);
                        end else begin
                            x <= x + FB_L2'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zbuff_resolve.sv
// ---------------------------------------------------------------------------
// tb_zbuff_resolve
//
// Directed bench for zbuff_resolve. Each frame pushes its expected pixels
// into a scoreboard queue; a monitor pops and compares on every handshake,
// and also checks handshake spacing where the frame enables it.
// ---------------------------------------------------------------------------
module tb_zbuff_resolve;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic signed [23:0] screen [1:0];
    logic [3:0]         sub_sample = 4'b1000;
    logic               rd_en;
    logic [27:0]        rd_addr;
    logic [35:0]        rd_data = '0;
    logic               pix_valid;
    logic               pix_ready = 1'b1;
    logic [10:0]        pix_x;
    logic [10:0]        pix_y;
    logic [11:0]        pix_color [2:0];
    logic               pix_last;
    logic               busy;
    logic               done;

    zbuff_resolve dut (
        .clk              (clk),
        .rst              (rst),
        .start_RnnnnH     (start),
        .screen_RnnnnS    (screen),
        .subSample_RnnnnU (sub_sample),
        .rd_en_RnnnnH     (rd_en),
        .rd_addr_RnnnnU   (rd_addr),
        .rd_data_RnnnnU   (rd_data),
        .pix_valid_RnnnnH (pix_valid),
        .pix_ready_RnnnnH (pix_ready),
        .pix_x_RnnnnU     (pix_x),
        .pix_y_RnnnnU     (pix_y),
        .pix_color_RnnnnU (pix_color),
        .pix_last_RnnnnH  (pix_last),
        .busy_RnnnnH      (busy),
        .done_RnnnnH      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [11:0] r;
        logic [11:0] g;
        logic [11:0] b;
        logic        last;
    } pix_t;

    pix_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    int t_start = 0;
    int exp_first = 0;
    int exp_period = 0;
    bit timing_on = 1'b0;
    int prev_hs = -1;
    int last_hs = -1;
    bit done_seen = 1'b0;
    int done_cyc = -1;
    int rd_cnt = 0;
    int valid_cnt = 0;
    int busy_cnt = 0;

`ifdef ZBUFF_RESOLVE_ROUND_EN
    localparam logic [11:0] EXP_R1 = 12'd8;   // (120+8)>>4
    localparam logic [11:0] EXP_G1 = 12'd2;   // (24+8)>>4
`else
    localparam logic [11:0] EXP_R1 = 12'd7;   // 120>>4
    localparam logic [11:0] EXP_G1 = 12'd1;   // 24>>4
`endif
    localparam logic [11:0] EXP_B1 = 12'd3;   // 48>>4 either way

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sample store contents, selected per frame by 'mode'.
    //   0: R = 4*y + x, G = x, B = y (independent of subsample)
    //   1: R = 4*ss_y + ss_x, G = ss_x, B = 3
    //   2: every channel 0xFFF
    function automatic logic [35:0] sram_word(input logic [27:0] a);
        logic [11:0] r;
        logic [11:0] g;
        logic [11:0] b;
        case (mode)
            0: begin
                r = 12'(a[27:17] * 4 + a[16:6]);
                g = 12'(a[16:6]);
                b = 12'(a[27:17]);
            end
            1: begin
                r = 12'(a[5:3] * 4 + a[2:0]);
                g = 12'(a[2:0]);
                b = 12'd3;
            end
            default: begin
                r = 12'hFFF;
                g = 12'hFFF;
                b = 12'hFFF;
            end
        endcase
        return {b, g, r};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= sram_word(rd_addr);
    end

    // Monitor: looks just after the falling edge, once stimulus for the
    // cycle has been driven.
    always begin
        pix_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            check("valid_with_rd_en", 32'(pix_valid & rd_en), 32'd0);
            if (rd_en) rd_cnt++;
            if (pix_valid) valid_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (pix_valid && pix_ready) begin
                check("pixel_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pix_x", 32'(pix_x), 32'(e.x));
                    check("pix_y", 32'(pix_y), 32'(e.y));
                    check("pix_r", 32'(pix_color[0]), 32'(e.r));
                    check("pix_g", 32'(pix_color[1]), 32'(e.g));
                    check("pix_b", 32'(pix_color[2]), 32'(e.b));
                    check("pix_last", 32'(pix_last), 32'(e.last));
                    if (timing_on) begin
                        if (prev_hs < 0) check("first_valid_lat", 32'(cyc - t_start), 32'(exp_first));
                        else             check("pixel_period", 32'(cyc - prev_hs), 32'(exp_period));
                    end
                    prev_hs = cyc;
                    if (e.last) last_hs = cyc;
                end
            end
        end
    end

    task automatic push_frame(input int w, input int h, input int md);
        pix_t p;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                p.x = 11'(xx);
                p.y = 11'(yy);
                case (md)
                    0: begin
                        p.r = 12'(yy * 4 + xx);
                        p.g = 12'(xx);
                        p.b = 12'(yy);
                    end
                    1: begin
                        p.r = EXP_R1;
                        p.g = EXP_G1;
                        p.b = EXP_B1;
                    end
                    default: begin
                        p.r = 12'hFFF;
                        p.g = 12'hFFF;
                        p.b = 12'hFFF;
                    end
                endcase
                p.last = (xx == w - 1) && (yy == h - 1);
                sb.push_back(p);
            end
        end
    endtask

    // Drives start for one cycle; returns at the falling edge of cycle T+1.
    task automatic start_frame(input int w, input int h, input logic [3:0] rate, input int md,
                               input int first, input int period, input bit timed);
        @(negedge clk);
        screen[0]  = 24'(w << 10);
        screen[1]  = 24'(h << 10);
        sub_sample = rate;
        mode       = md;
        exp_first  = first;
        exp_period = period;
        timing_on  = timed;
        prev_hs    = -1;
        last_hs    = -1;
        done_seen  = 1'b0;
        done_cyc   = -1;
        rd_cnt     = 0;
        valid_cnt  = 0;
        busy_cnt   = 0;
        push_frame(w, h, md);
        start      = 1'b1;
        t_start    = cyc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_seen && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 32'(done_seen), 32'd1);
        @(negedge clk);
        #2;
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_rd_en"}, 32'(rd_en), 32'd0);
        check({name, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({name, "_pix_valid"}, 32'(pix_valid), 32'd0);
        check({name, "_pix_x"}, 32'(pix_x), 32'd0);
        check({name, "_pix_y"}, 32'(pix_y), 32'd0);
        check({name, "_pix_color"}, 32'({pix_color[2], pix_color[1], pix_color[0]} != 36'd0), 32'd0);
        check({name, "_pix_last"}, 32'(pix_last), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL global_timeout: got %0d cycles expected fewer", cyc);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [10:0] snap_x;
        logic [10:0] snap_y;
        logic [11:0] snap_r;
        logic        snap_last;
        int n;

        screen[0] = '0;
        screen[1] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;

        // 4x4, one sample per pixel: period 3, first valid at T+3
        start_frame(4, 4, 4'b1000, 0, 3, 3, 1'b1);
        wait_done("frame4x4");
        check("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
        check("rd_count_4x4", 32'(rd_cnt), 32'd16);

        // 2x2, 16 samples per pixel: period 18
        start_frame(2, 2, 4'b0010, 1, 18, 18, 1'b1);
        wait_done("frame2x2_ss4");

        // 1x1, 64 saturated samples: valid at T+66
        start_frame(1, 1, 4'b0001, 2, 66, 0, 1'b1);
        wait_done("frame1x1_ss8");
        check("rd_count_1x1", 32'(rd_cnt), 32'd64);

        // Backpressure on the first pixel of a 2x2 frame
        pix_ready = 1'b0;
        start_frame(2, 2, 4'b1000, 0, 0, 0, 1'b0);
        n = 0;
        while (!pix_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(pix_valid), 32'd1);
        snap_x    = pix_x;
        snap_y    = pix_y;
        snap_r    = pix_color[0];
        snap_last = pix_last;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 32'(pix_valid), 32'd1);
            check("bp_x_stable", 32'(pix_x), 32'(snap_x));
            check("bp_y_stable", 32'(pix_y), 32'(snap_y));
            check("bp_color_stable", 32'(pix_color[0]), 32'(snap_r));
            check("bp_last_stable", 32'(pix_last), 32'(snap_last));
            check("bp_no_read", 32'(rd_en), 32'd0);
            @(negedge clk);
        end
        pix_ready = 1'b1;
        @(negedge clk);
        check("bp_read_after_hs", 32'(rd_en), 32'd1);
        check("bp_valid_dropped", 32'(pix_valid), 32'd0);
        wait_done("frame_bp");

        // Zero-width screen
        start_frame(0, 4, 4'b1000, 0, 0, 0, 1'b0);
        check("empty_done_t1", 32'(done), 32'd1);
        check("empty_busy_t1", 32'(busy), 32'd1);
        @(negedge clk);
        check("empty_busy_t2", 32'(busy), 32'd0);
        check("empty_done_t2", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("empty_rd_count", 32'(rd_cnt), 32'd0);
        check("empty_valid_count", 32'(valid_cnt), 32'd0);
        check("empty_busy_count", 32'(busy_cnt), 32'd1);

        // Reset during the READ of pixel (1,0), then a clean frame with an
        // extra start while busy
        start_frame(4, 4, 4'b0100, 0, 6, 6, 1'b1);
        n = 0;
        while (!(rd_en && rd_addr[16:6] == 11'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_read_reached", 32'(rd_en && rd_addr[16:6] == 11'd1), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        sb.delete();
        rst = 1'b1;
        start_frame(4, 4, 4'b0100, 0, 6, 6, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("frame_after_reset");
        check("rd_count_after_reset", 32'(rd_cnt), 32'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zbuff_resolve.md
# zbuff_resolve

Synthesizable multisample resolve engine: the reader side of the z-buffer sample store. After a frame is rasterized, it scans the subsample color buffer in raster order and averages each pixel's ss_rate subsamples into one color. It streams the resolved pixels to the image writer or scanout over a valid/ready handshake. It sits between the on-chip sample SRAM and the frame output path.

## Interface
- SIGFIG, 24, bits in fixed-point screen dimensions
- RADIX, 10, fraction bits in screen dimensions
- FB_L2, 11, bits per pixel coordinate
- SS_L2, 3, bits per subsample-axis index (max 8 per axis)
- COLORS, 3, color channels
- COLORP, 12, bits per stored and resolved color channel

- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-low reset (rst==0 resets)
- start_RnnnnH  in  1  begin resolve; sampled only in IDLE
- screen_RnnnnS[1:0]  in  SIGFIG signed  {height,width} fixed point; integer part [SIGFIG-1:RADIX] used
- subSample_RnnnnU  in  4  one-hot per-axis rate: 1000=1, 0100=2, 0010=4, 0001=8
- rd_en_RnnnnH  out  1  sample SRAM read strobe
- rd_addr_RnnnnU  out  2*FB_L2+2*SS_L2  {y, x, ss_y, ss_x}
- rd_data_RnnnnU  in  COLORS*COLORP  sample color, channel 0 in LSBs, valid one cycle after rd_en
- pix_valid_RnnnnH  out  1  resolved pixel available
- pix_ready_RnnnnH  in  1  consumer accepts pixel
- pix_x_RnnnnU, pix_y_RnnnnU  out  FB_L2  pixel coordinate
- pix_color_RnnnnU[COLORS-1:0]  out  COLORP  resolved color
- pix_last_RnnnnH  out  1  final pixel of frame
- busy_RnnnnH  out  1  high in any non-IDLE state
- done_RnnnnH  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, READ, ACC, OUT, DONE.
- IDLE + start: latch x_max, y_max and the rate.
  - n = 1/2/4/8 and shift = 0/2/4/6.
  - A non-one-hot subSample value is treated as 1000.
  - Clear x, y, ss counters.
  - If x_max==0 or y_max==0, go to DONE. Otherwise go to READ.
- READ: issue one read per cycle over n*n cycles.
  - ss_x is the fastest index, then ss_y.
  - Unused high ss address bits are 0.
  - rd_en is high only in READ.
- Accumulator: one per channel, width COLORP+6, cleared on entry to READ.
  - Adds rd_data the cycle after each rd_en.
- ACC: one cycle. Absorbs the last sample and loads the output register with acc>>shift, truncated.
- OUT: pix_valid high. Coordinate, color and last are held stable until pix_valid&pix_ready.
  - On the handshake edge with the last pixel (x==x_max-1, y==y_max-1): go to DONE.
  - Otherwise advance x; on x wrap, reset x to 0 and increment y. Then go to READ.
- DONE: done high for one cycle, then IDLE.
- start in any state other than IDLE is ignored.
- Config inputs are not re-sampled mid-frame.
- Reset (rst==0) at any cycle:
  - State returns to IDLE and counters and accumulators clear.
  - The in-progress pixel is discarded.

## Timing
- Reset values: every output is 0, including rd_addr, pix_x, pix_y and pix_color; state is IDLE.
- Start sampled at edge T.
  - T+1: READ and the first rd_en, or DONE for an empty screen (done high in T+1).
  - The last read is at T+n*n.
  - ACC is at T+n*n+1.
  - pix_valid is first high at T+n*n+2.
- Minimum pixel period is n*n+2 cycles.
- Backpressure adds one cycle per cycle that pix_ready is low in OUT. No reads are issued while in OUT.
- The next READ begins the cycle after the handshake.
- pix_valid falls the cycle after the handshake. It is never high in the same cycle as rd_en.
- Accumulator cannot overflow: 64*(2^COLORP-1) < 2^(COLORP+6).

## Configuration
- ZBUFF_RESOLVE_ROUND_EN
  - Defined: the ACC result is (acc + (1<<(shift-1)))>>shift when shift>0, giving round-half-up; shift==0 passes through unchanged.
  - Undefined: plain truncation (acc>>shift).
  - Timing is identical in both cases.

## Test plan
- 4x4 screen (0x001000 each), rate 1000, SRAM holds R=addr → 16 pixels in raster order with R equal to the pixel's address.
  - pix_last only on (3,3); done pulses the cycle after the last handshake; per-pixel period 3 cycles with ready tied high.
- 2x2 screen, rate 0010 (16 samples), sample R values 0..15 per pixel → R=7 (120>>4).
  - With ZBUFF_RESOLVE_ROUND_EN → R=8.
  - 18 cycles per pixel.
- 1x1 screen, rate 0001, all samples 0xFFF → color 0xFFF on all channels; 64 rd_en pulses; pix_valid at T+66.
- pix_ready low for 5 cycles in OUT → pix_valid and all pixel fields stable, rd_en stays 0, and the next READ starts the cycle after ready rises.
- screen width 0 → no rd_en, no pix_valid, done high at T+1, busy high for only that cycle.
- rst=0 during READ of pixel (1,0), then start → all outputs 0 the cycle after reset; the new frame begins at (0,0); a start pulse issued while busy is ignored.
